mdl_mskreg_mc: RTL



---
 rtl/mskreg_pkg.sv | 24 ++
 rtl/mdl_mskreg_ch.sv | 96 +++++++++
 rtl/mdl_mskreg_mc.sv | 91 +++++++++
 3 files changed

// File: rtl/mskreg_pkg.sv
// Shared types for the multi-channel mask register.
//   state_e   : per-channel lifecycle (IDLE, ARMED, SHIFTING, EXHAUSTED)
//   sr_ctrl_e : action applied to a channel shift register on a clock edge
//   cnt_w()   : width of a counter that must hold the value DW
package mskreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_SHIFTING  = 2'd2,
    ST_EXHAUSTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_SHIFT = 2'b01,
    SR_LOAD  = 2'b10
  } sr_ctrl_e;

  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/mdl_mskreg_ch.sv
// One mask-register channel: DW-bit shift register, shift counter and
// lifecycle FSM.
// Ports:
//   clk, rst_n : master clock, synchronous active-low reset
//   ctrl       : HOLD / SHIFT / LOAD for this edge (already gated by slot+enable)
//   fill       : bit inserted at the MSB on a shift
//   latch      : shared holding latch (value before any same-edge write)
//   lsb        : serial mask bit (SR[0])
//   exh        : channel has shifted DW bits since its last load
//   busy       : channel is ARMED or SHIFTING
//   wrap       : (MSKREG_AUTORELOAD_EN only) one-cycle pulse on circular reload
// Optional feature macro: MSKREG_AUTORELOAD_EN
module mdl_mskreg_ch
  import mskreg_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  sr_ctrl_e      ctrl,
  input  logic          fill,
  input  logic [DW-1:0] latch,
  output logic          lsb,
  output logic          exh,
  output logic          busy
`ifdef MSKREG_AUTORELOAD_EN
  ,
  output logic          wrap
`endif
);

  localparam int CW = cnt_w(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DW);

  logic [DW-1:0] sr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  state_e        state;

  // Counter saturates at DW so EXHAUSTED can be held indefinitely.
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
`ifdef MSKREG_AUTORELOAD_EN
      wrap  <= 1'b0;
`endif
    end else begin
`ifdef MSKREG_AUTORELOAD_EN
      wrap <= 1'b0;
`endif
      case (ctrl)
        SR_LOAD: begin
          sr    <= latch;
          cnt   <= '0;
          state <= ST_ARMED;
        end
        SR_SHIFT: begin
`ifdef MSKREG_AUTORELOAD_EN
          // Circular mask: the shift that would complete DW bits reloads instead.
          if (cnt_inc == CNT_MAX) begin
            sr    <= latch;
            cnt   <= '0;
            wrap  <= 1'b1;
            state <= (state == ST_IDLE) ? ST_IDLE : ST_SHIFTING;
          end else begin
            sr    <= {fill, sr[DW-1:1]};
            cnt   <= cnt_inc;
            state <= (state == ST_IDLE) ? ST_IDLE : ST_SHIFTING;
          end
`else
          sr  <= {fill, sr[DW-1:1]};
          cnt <= cnt_inc;
          case (state)
            ST_IDLE:     state <= ST_IDLE;
            ST_ARMED,
            ST_SHIFTING: state <= (cnt_inc == CNT_MAX) ? ST_EXHAUSTED : ST_SHIFTING;
            default:     state <= ST_EXHAUSTED;
          endcase
`endif
        end
        default: ;
      endcase
    end
  end

  assign lsb  = sr[0];
  assign exh  = (state == ST_EXHAUSTED);
  assign busy = (state == ST_ARMED) || (state == ST_SHIFTING);

endmodule

// File: rtl/mdl_mskreg_mc.sv
// Multi-channel bubble-memory mask register. A shared DW-bit holding latch
// (written from the CPU bus) feeds NCH load/shift channels, each serviced on
// its own rotation-timing slot (ROT bit c*STEP).
// Ports:
//   i_MCLK, i_RST_n   : master clock, synchronous active-low reset
//   i_CLK4M_PCEN_n    : latch write enable (active-low)
//   i_CLK2M_PCEN_n    : shift-register enable (active-low)
//   i_ROT_n           : one-cold rotation timing vector
//   i_4BEN_n          : low enables the upper half of the channels
//   i_MSKREG_LD       : latch write strobe
//   i_MSKREG_SR_LD    : load request (high) / shift (low)
//   i_BOOTEN_n        : low = boot mode (always shift, fill with 1)
//   i_DIN             : mask data
//   o_MSKREG_SR_LSB   : serial mask bit per channel
//   o_EXH             : per-channel exhaustion
//   o_WRAP            : per-channel reload pulse (MSKREG_AUTORELOAD_EN only)
//   o_BUSY            : any channel ARMED or SHIFTING
// Optional feature macro: MSKREG_AUTORELOAD_EN
module mdl_mskreg_mc
  import mskreg_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NCH  = 4,
  parameter int ROTW = 20
) (
  input  logic            i_MCLK,
  input  logic            i_RST_n,
  input  logic            i_CLK4M_PCEN_n,
  input  logic            i_CLK2M_PCEN_n,
  input  logic [ROTW-1:0] i_ROT_n,
  input  logic            i_4BEN_n,
  input  logic            i_MSKREG_LD,
  input  logic            i_MSKREG_SR_LD,
  input  logic            i_BOOTEN_n,
  input  logic [DW-1:0]   i_DIN,
  output logic [NCH-1:0]  o_MSKREG_SR_LSB,
  output logic [NCH-1:0]  o_EXH,
`ifdef MSKREG_AUTORELOAD_EN
  output logic [NCH-1:0]  o_WRAP,
`endif
  output logic            o_BUSY
);

  localparam int STEP = ROTW / NCH;

  logic [DW-1:0]  latch;
  logic [NCH-1:0] slot;
  logic [NCH-1:0] busy;
  logic           ld;
  logic           unused_rot;

  // Only every STEP-th rotation bit selects a channel.
  assign unused_rot = ^i_ROT_n;

  // Boot mode turns every load request into a shift.
  assign ld = i_MSKREG_SR_LD & i_BOOTEN_n;

  // Channels read the latch before this edge's write lands.
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      latch <= '0;
    end else if (!i_CLK4M_PCEN_n && i_MSKREG_LD) begin
      latch <= i_DIN;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sr_ctrl_e ctrl;

    assign slot[c] = ~i_ROT_n[c*STEP] & ((c < NCH/2) | ~i_4BEN_n);
    assign ctrl    = (!i_CLK2M_PCEN_n && slot[c]) ? (ld ? SR_LOAD : SR_SHIFT) : SR_HOLD;

    mdl_mskreg_ch #(.DW(DW)) u_ch (
      .clk   (i_MCLK),
      .rst_n (i_RST_n),
      .ctrl  (ctrl),
      .fill  (~i_BOOTEN_n),
      .latch (latch),
      .lsb   (o_MSKREG_SR_LSB[c]),
      .exh   (o_EXH[c]),
      .busy  (busy[c])
`ifdef MSKREG_AUTORELOAD_EN
      ,
      .wrap  (o_WRAP[c])
`endif
    );
  end

  assign o_BUSY = |busy;

endmodule
